// File: rtl/uart_receiver.sv
// Serial receiver for btint column traffic: recovers 11-bit frames of interleaved (a,b) digit
// pairs and assembles four 8-digit elements into one column word with a one-cycle valid strobe.
module uart_receiver #(
   parameter int unsigned BIT_PERIOD = 10000000,
   parameter int unsigned CNT_W      = 24,
   parameter int unsigned ELEMENTS   = 4
) (
   input  logic        uart_receiver_clock,
   input  logic        uart_receiver_reset,
   input  logic        uart_receiver_input,
   output logic [31:0] uart_receiver_output_btint_a,
   output logic [31:0] uart_receiver_output_btint_b,
   output logic        uart_receiver_output_valid,
   output logic        uart_receiver_frame_error,
   output logic [1:0]  uart_receiver_column
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BIT_PERIOD / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BIT_PERIOD - 1);
   localparam logic [1:0]       LAST_ELEM   = 2'(ELEMENTS - 1);

   logic             sync1, rx_s;
   state_t           state, state_n;
   logic             armed, armed_n;
   logic [CNT_W-1:0] timer, timer_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic             stop_idx, stop_idx_n;
   logic [7:0]       data, data_n;
   logic             nib, nib_n;
   logic [1:0]       elem, elem_n;
   logic [31:0]      asm_a, asm_a_n, asm_b, asm_b_n;
   logic [31:0]      merged_a, merged_b;
   logic [31:0]      out_a, out_a_n, out_b, out_b_n;
   logic             valid, valid_n, ferr, ferr_n;
   logic [1:0]       column, column_n;
   logic [4:0]       pos;

   always_ff @(posedge uart_receiver_clock) begin
      if (uart_receiver_reset) begin
         sync1    <= 1'b1;
         rx_s     <= 1'b1;
         state    <= IDLE;
         armed    <= 1'b1;
         timer    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         data     <= '0;
         nib      <= 1'b0;
         elem     <= '0;
         asm_a    <= '0;
         asm_b    <= '0;
         out_a    <= '0;
         out_b    <= '0;
         valid    <= 1'b0;
         ferr     <= 1'b0;
         column   <= '0;
      end else begin
         sync1    <= uart_receiver_input;
         rx_s     <= sync1;
         state    <= state_n;
         armed    <= armed_n;
         timer    <= timer_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         data     <= data_n;
         nib      <= nib_n;
         elem     <= elem_n;
         asm_a    <= asm_a_n;
         asm_b    <= asm_b_n;
         out_a    <= out_a_n;
         out_b    <= out_b_n;
         valid    <= valid_n;
         ferr     <= ferr_n;
         column   <= column_n;
      end
   end

   always_comb begin
      state_n    = state;
      armed_n    = armed;
      timer_n    = (timer == '0) ? timer : timer - CNT_W'(1);
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      data_n     = data;
      nib_n      = nib;
      elem_n     = elem;
      asm_a_n    = asm_a;
      asm_b_n    = asm_b;
      out_a_n    = out_a;
      out_b_n    = out_b;
      valid_n    = 1'b0;
      ferr_n     = 1'b0;
      column_n   = column;
      pos        = '0;

      // Current frame merged into the assembly word: element e in byte (3-e), nibble nib.
      merged_a = asm_a;
      merged_b = asm_b;
      for (int unsigned m = 0; m < 4; m++) begin
         pos = {~elem, nib, m[1:0]};
         merged_a[pos] = data[{m[1:0], 1'b0}];
         merged_b[pos] = data[{m[1:0], 1'b1}];
      end

      unique case (state)
         IDLE: begin
            // After a break the line must return high before a new start is accepted.
            if (rx_s) begin
               armed_n = 1'b1;
            end else if (armed) begin
               state_n = START;
               timer_n = HALF_RELOAD;
            end
         end
         START: begin
            if (timer == '0) begin
               if (!rx_s) begin
                  state_n   = DATA;
                  bit_idx_n = '0;
                  timer_n   = FULL_RELOAD;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (timer == '0) begin
               data_n[bit_idx] = rx_s;
               timer_n         = FULL_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_n    = STOP;
                  stop_idx_n = 1'b0;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (timer == '0) begin
               if (!rx_s) begin
                  ferr_n  = 1'b1;
                  armed_n = 1'b0;
                  nib_n   = 1'b0;
                  elem_n  = '0;
                  asm_a_n = '0;
                  asm_b_n = '0;
                  state_n = IDLE;
               end else if (!stop_idx) begin
                  stop_idx_n = 1'b1;
                  timer_n    = FULL_RELOAD;
               end else begin
                  state_n = IDLE;
                  if (nib && elem == LAST_ELEM) begin
                     out_a_n  = merged_a;
                     out_b_n  = merged_b;
                     valid_n  = 1'b1;
                     column_n = column + 2'd1;
                     nib_n    = 1'b0;
                     elem_n   = '0;
                     asm_a_n  = '0;
                     asm_b_n  = '0;
                  end else begin
                     asm_a_n = merged_a;
                     asm_b_n = merged_b;
                     nib_n   = ~nib;
                     if (nib) elem_n = elem + 2'd1;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign uart_receiver_output_btint_a = out_a;
   assign uart_receiver_output_btint_b = out_b;
   assign uart_receiver_output_valid   = valid;
   assign uart_receiver_frame_error    = ferr;
   assign uart_receiver_column         = column;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at BIT_PERIOD=16: clean columns, glitch, stop error,
// mid-frame reset, back-to-back columns with wrap, and line break.
module tb_uart_receiver;

   localparam int BP = 16;
   localparam int COL_CYCLES = 8 * 11 * BP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        line = 1'b1;
   logic [31:0] btint_a, btint_b;
   logic        valid, ferr;
   logic [1:0]  column;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int vcount = 0;
   int fcount = 0;
   int both = 0;
   logic [31:0] cap_a[$];
   logic [31:0] cap_b[$];
   logic [31:0] cap_col[$];
   int          cap_cyc[$];

   uart_receiver #(.BIT_PERIOD(BP), .CNT_W(8), .ELEMENTS(4)) dut (
      .uart_receiver_clock          (clk),
      .uart_receiver_reset          (rst),
      .uart_receiver_input          (line),
      .uart_receiver_output_btint_a (btint_a),
      .uart_receiver_output_btint_b (btint_b),
      .uart_receiver_output_valid   (valid),
      .uart_receiver_frame_error    (ferr),
      .uart_receiver_column         (column)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         vcount++;
         cap_a.push_back(btint_a);
         cap_b.push_back(btint_b);
         cap_col.push_back({30'd0, column});
         cap_cyc.push_back(cyc);
      end
      if (ferr) fcount++;
      if (valid && ferr) both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      line = v;
      tick(BP);
   endtask

   // Frame k of a column: element k/2, nibble k%2; d(2m)=a digit, d(2m+1)=b digit.
   task automatic send_frame_k(input logic [31:0] a, input logic [31:0] b, input int k, input logic s1);
      logic [7:0] ab, bb, f;
      int e, nb;
      e  = k / 2;
      nb = k % 2;
      ab = a[(3-e)*8 +: 8];
      bb = b[(3-e)*8 +: 8];
      for (int m = 0; m < 4; m++) begin
         f[2*m]   = ab[nb*4+m];
         f[2*m+1] = bb[nb*4+m];
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(f[i]);
      send_bit(s1);
      send_bit(1'b1);
   endtask

   task automatic send_column(input logic [31:0] a, input logic [31:0] b);
      for (int k = 0; k < 8; k++) send_frame_k(a, b, k, 1'b1);
   endtask

   logic [31:0] t5_a[4] = '{32'h01234567, 32'h89ABCDEF, 32'hFFFF0000, 32'h0000FFFF};
   logic [31:0] t5_b[4] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h00FF00FF, 32'hF0F0F0F0};
   logic [31:0] t5_col[4] = '{32'd2, 32'd3, 32'd0, 32'd1};

   initial begin
      int v0, f0, base;
      tick(3);
      check("rst_a", btint_a, 32'h0);
      check("rst_b", btint_b, 32'h0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ferr", {31'd0, ferr}, 32'd0);
      check("rst_col", {30'd0, column}, 32'd0);
      rst = 1'b0;
      tick(2 * BP);

      // 1: clean column
      send_column(32'h5A01FF80, 32'h0F003CC3);
      tick(BP);
      check("t1_vcount", vcount, 1);
      check("t1_a", btint_a, 32'h5A01FF80);
      check("t1_b", btint_b, 32'h0F003CC3);
      check("t1_col", {30'd0, column}, 32'd1);
      check("t1_fcount", fcount, 0);

      // 2: short low glitch rejected
      line = 1'b0;
      tick(4);
      line = 1'b1;
      tick(3 * BP);
      check("t2_glitch_v", vcount, 1);
      check("t2_glitch_f", fcount, 0);
      send_column(32'h12345678, 32'h9ABCDEF0);
      tick(BP);
      check("t2_vcount", vcount, 2);
      check("t2_a", btint_a, 32'h12345678);
      check("t2_b", btint_b, 32'h9ABCDEF0);
      check("t2_col", {30'd0, column}, 32'd2);

      // 3: first stop bit low on frame 3 discards the column
      send_frame_k(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1);
      send_frame_k(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b1);
      send_frame_k(32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0);
      tick(2 * BP);
      check("t3_ferr", fcount, 1);
      check("t3_novalid", vcount, 2);
      check("t3_hold_a", btint_a, 32'h12345678);
      send_column(32'hCAFEBABE, 32'h13579BDF);
      tick(BP);
      check("t3_vcount", vcount, 3);
      check("t3_a", btint_a, 32'hCAFEBABE);
      check("t3_b", btint_b, 32'h13579BDF);
      check("t3_col", {30'd0, column}, 32'd3);

      // 4: reset during frame 5 data bits
      for (int k = 0; k < 4; k++) send_frame_k(32'h77777777, 32'h77777777, k, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b1;
      line = 1'b1;
      tick(2);
      check("t4_rst_a", btint_a, 32'h0);
      check("t4_rst_b", btint_b, 32'h0);
      check("t4_rst_col", {30'd0, column}, 32'd0);
      rst = 1'b0;
      tick(12 * BP);
      check("t4_novalid", vcount, 3);
      check("t4_noferr", fcount, 1);
      send_column(32'h0F1E2D3C, 32'h4B5A6978);
      tick(BP);
      check("t4_vcount", vcount, 4);
      check("t4_a", btint_a, 32'h0F1E2D3C);
      check("t4_b", btint_b, 32'h4B5A6978);
      check("t4_col", {30'd0, column}, 32'd1);

      // 5: four back-to-back columns
      base = cap_a.size();
      for (int c = 0; c < 4; c++) send_column(t5_a[c], t5_b[c]);
      tick(BP);
      check("t5_count", cap_a.size() - base, 4);
      for (int c = 0; c < 4; c++) begin
         if (base + c < cap_a.size()) begin
            check($sformatf("t5_a%0d", c), cap_a[base+c], t5_a[c]);
            check($sformatf("t5_b%0d", c), cap_b[base+c], t5_b[c]);
            check($sformatf("t5_col%0d", c), cap_col[base+c], t5_col[c]);
            if (c > 0) check($sformatf("t5_gap%0d", c), cap_cyc[base+c] - cap_cyc[base+c-1], COL_CYCLES);
         end
      end
      check("t5_ferr", fcount, 1);

      // 6: break gives exactly one frame error
      v0 = vcount;
      f0 = fcount;
      line = 1'b0;
      tick(40 * BP);
      line = 1'b1;
      tick(2 * BP);
      check("t6_ferr", fcount - f0, 1);
      check("t6_novalid", vcount - v0, 0);
      send_column(32'hA5C3E187, 32'h7E81DB24);
      tick(BP);
      check("t6_vcount", vcount - v0, 1);
      check("t6_a", btint_a, 32'hA5C3E187);
      check("t6_b", btint_b, 32'h7E81DB24);
      check("t6_col", {30'd0, column}, 32'd2);

      check("no_overlap", both, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
